// File: rtl/min_search_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : min_search_sequencer
// Purpose  : Clears the min register, streams SAD candidates with raster tags,
//            then hands the winning value/position over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module min_search_sequencer #(
    parameter int VAL_W = 13,
    parameter int TAG_W = 32,
    parameter int DIM_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [DIM_W-1:0] num_rows,
    input  logic [DIM_W-1:0] num_cols,
    input  logic             sad_valid,
    input  logic [VAL_W-1:0] sad_value,
    output logic             sad_ready,
    output logic             max_out,
    output logic             min_in,
    output logic [VAL_W-1:0] cand,
    output logic [TAG_W-1:0] tag,
    input  logic             out_smaller,
    input  logic [VAL_W-1:0] out_stored,
    input  logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [VAL_W-1:0] res_value,
    output logic [DIM_W-1:0] res_row,
    output logic [DIM_W-1:0] res_col,
    output logic [DIM_W-1:0] res_updates
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_SETTLE = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DIM_W-1:0] r_nrows;
    logic [DIM_W-1:0] r_ncols;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_upd;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_zero;

    assign w_col_last = (r_col == r_ncols - DIM_W'(1));
    assign w_row_last = (r_row == r_nrows - DIM_W'(1));
    assign w_zero     = (num_rows == '0) || (num_cols == '0);

    assign min_in = sad_valid & sad_ready;
    assign cand   = sad_value;
    assign tag    = {r_row, r_col};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        sad_ready = 1'b0;
        max_out   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // A zero-sized window has nothing to stream; report the register as is.
                    w_next = w_zero ? S_SETTLE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                max_out = 1'b1;
                w_next  = S_STREAM;
            end
            S_STREAM: begin
                sad_ready = 1'b1;
                if (sad_valid && w_col_last && w_row_last) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_next = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_nrows     <= '0;
            r_ncols     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_upd       <= '0;
            res_value   <= '0;
            res_row     <= '0;
            res_col     <= '0;
            res_updates <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nrows <= num_rows;
                        r_ncols <= num_cols;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_upd   <= '0;
                    end
                end
                S_STREAM: begin
                    if (sad_valid) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_W'(1);
                        end else begin
                            r_col <= r_col + DIM_W'(1);
                        end
                        if (out_smaller) begin
                            r_upd <= r_upd + DIM_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    // Min register has absorbed the last candidate by now.
                    res_value   <= out_stored;
                    res_row     <= out_tag[TAG_W-1 -: DIM_W];
                    res_col     <= out_tag[DIM_W-1:0];
                    res_updates <= r_upd;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_min_search_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_min_search_sequencer
// Purpose  : Scoreboard bench with a behavioural min register and reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_min_search_sequencer;

    localparam int VAL_W = 13;
    localparam int TAG_W = 32;
    localparam int DIM_W = 16;

    logic             Clk;
    logic             Reset;
    logic             start;
    logic [DIM_W-1:0] num_rows;
    logic [DIM_W-1:0] num_cols;
    logic             sad_valid;
    logic [VAL_W-1:0] sad_value;
    logic             sad_ready;
    logic             max_out;
    logic             min_in;
    logic [VAL_W-1:0] cand;
    logic [TAG_W-1:0] tag;
    logic             out_smaller;
    logic [VAL_W-1:0] mr_val = '1;
    logic [TAG_W-1:0] mr_tag = '1;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [VAL_W-1:0] res_value;
    logic [DIM_W-1:0] res_row;
    logic [DIM_W-1:0] res_col;
    logic [DIM_W-1:0] res_updates;

    typedef struct packed {
        logic [VAL_W-1:0] v;
        logic [DIM_W-1:0] r;
        logic [DIM_W-1:0] c;
        logic [DIM_W-1:0] u;
    } res_t;

    res_t             exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [VAL_W-1:0] stim [0:255];
    int               stim_n    = 0;
    int               stim_cols = 1;
    bit               gap_en    = 1'b0;
    int               mo_cnt    = 0;
    int               done_cnt  = 0;
    int               feed_idx  = 0;

    min_search_sequencer #(.VAL_W(VAL_W), .TAG_W(TAG_W), .DIM_W(DIM_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .num_rows    (num_rows),
        .num_cols    (num_cols),
        .sad_valid   (sad_valid),
        .sad_value   (sad_value),
        .sad_ready   (sad_ready),
        .max_out     (max_out),
        .min_in      (min_in),
        .cand        (cand),
        .tag         (tag),
        .out_smaller (out_smaller),
        .out_stored  (mr_val),
        .out_tag     (mr_tag),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_value   (res_value),
        .res_row     (res_row),
        .res_col     (res_col),
        .res_updates (res_updates)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural min register: clears to all-ones, keeps strictly smaller values.
    assign out_smaller = (cand < mr_val);
    always @(posedge Clk) begin
        if (max_out) begin
            mr_val <= '1;
            mr_tag <= '1;
        end else if (min_in && out_smaller) begin
            mr_val <= cand;
            mr_tag <= tag;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: scan the window in raster order; first strictly smaller wins.
    function automatic res_t ref_result(input int rows, input int cols);
        res_t r;
        r.v = '1;
        r.r = '1;
        r.c = '1;
        r.u = '0;
        for (int i = 0; i < rows * cols; i++) begin
            if (stim[i] < r.v) begin
                r.v = stim[i];
                r.r = DIM_W'(i / cols);
                r.c = DIM_W'(i % cols);
                r.u = r.u + DIM_W'(1);
            end
        end
        return r;
    endfunction

    // Monitor: result handshakes against the scoreboard, plus clear pulses.
    initial begin
        res_t e;
        forever begin
            @(negedge Clk);
            if (max_out) mo_cnt++;
            if (!Reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", res_value);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_value",   64'(res_value),   64'(e.v));
                    chk("res_row",     64'(res_row),     64'(e.r));
                    chk("res_col",     64'(res_col),     64'(e.c));
                    chk("res_updates", 64'(res_updates), 64'(e.u));
                end
                done_cnt++;
            end
        end
    end

    // Candidate feeder: presents stim[feed_idx], checks the tag on each accept.
    initial begin
        sad_valid = 1'b0;
        sad_value = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                feed_idx = 0;
            end else if (start && !busy) begin
                feed_idx = 0;
            end else if (sad_valid && sad_ready) begin
                chk("tag", 64'(tag), 64'({DIM_W'(feed_idx / stim_cols), DIM_W'(feed_idx % stim_cols)}));
                chk("min_in_cand", 64'({min_in, cand}), 64'({1'b1, sad_value}));
                feed_idx++;
            end
            @(posedge Clk);
            #1;
            if (feed_idx < stim_n && !(gap_en && $urandom_range(0, 2) == 0)) begin
                sad_valid = 1'b1;
                sad_value = stim[feed_idx];
            end else begin
                sad_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic run(input int rows, input int cols, input bit gaps, input bit lat_chk, input bit hold);
        int   k;
        int   n;
        int   mo0;
        int   done0;
        logic [VAL_W+3*DIM_W-1:0] snap;
        n = rows * cols;
        exp_q.push_back(ref_result(rows, cols));
        stim_n    = n;
        stim_cols = (cols == 0) ? 1 : cols;
        gap_en    = gaps;
        res_ready = !hold;
        mo0       = mo_cnt;
        done0     = done_cnt;
        start     = 1'b1;
        num_rows  = DIM_W'(rows);
        num_cols  = DIM_W'(cols);
        k = 0;
        do begin
            tick();
            k++;
            start = 1'b0;
        end while (!res_valid && k < 2000);
        chk("res_valid_rise", 64'(res_valid), 64'(1));
        // Counted in clock edges from the cycle in which start is raised.
        if (lat_chk) chk("latency", 64'(k), 64'(n + 3));
        if (hold) begin
            snap = {res_value, res_row, res_col, res_updates};
            for (int i = 0; i < 5; i++) begin
                start    = (i == 1);
                num_rows = DIM_W'(2);
                num_cols = DIM_W'(2);
                tick();
                chk("hold_stable", 64'({res_valid, busy, res_value, res_row, res_col, res_updates}),
                    64'({2'b11, snap}));
            end
            start     = 1'b0;
            res_ready = 1'b1;
        end
        k = 0;
        while (done_cnt == done0 && k < 100) begin
            tick();
            k++;
        end
        tick();
        chk("handshakes", 64'(done_cnt - done0), 64'(1));
        chk("idle_after_handshake", 64'({busy, res_valid}), 64'(0));
        chk("max_out_pulses", 64'(mo_cnt - mo0), 64'((n == 0) ? 0 : 1));
    endtask

    initial begin
        int k;
        int r;
        int c;
        Reset     = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        num_rows  = '0;
        num_cols  = '0;
        repeat (2) tick();
        chk("reset_ctrl", 64'({busy, max_out, sad_ready, res_valid}), 64'(0));
        chk("reset_tag", 64'(tag), 64'(0));
        chk("reset_res", 64'({res_value, res_row, res_col, res_updates}), 64'(0));
        Reset = 1'b0;
        tick();

        // 1x1 all-ones candidate: register cleared, nothing strictly smaller.
        stim[0] = '1;
        run(1, 1, 1'b0, 1'b1, 1'b0);
        // Zero-sized windows against the now-cleared register.
        run(0, 5, 1'b0, 1'b0, 1'b0);
        run(3, 0, 1'b0, 1'b0, 1'b0);

        // 4x4 with a single minimum at (2,1).
        for (int i = 0; i < 16; i++) stim[i] = VAL_W'(100 + i);
        stim[9] = VAL_W'(7);
        run(4, 4, 1'b0, 1'b1, 1'b0);

        // 3x3 tie: earliest raster position (0,2) must win.
        for (int i = 0; i < 9; i++) stim[i] = VAL_W'(50);
        stim[2] = VAL_W'(5);
        stim[6] = VAL_W'(5);
        run(3, 3, 1'b0, 1'b1, 1'b0);

        // 8x2 gap-free, then the same window with random stalls.
        for (int i = 0; i < 16; i++) stim[i] = VAL_W'($urandom_range(0, 300));
        run(8, 2, 1'b0, 1'b1, 1'b0);
        run(8, 2, 1'b1, 1'b0, 1'b0);

        // Backpressure with a start attempt during RESULT.
        for (int i = 0; i < 6; i++) stim[i] = VAL_W'($urandom_range(0, 30));
        run(3, 2, 1'b1, 1'b0, 1'b1);

        // Back-to-back: small values, then strictly larger ones.
        for (int i = 0; i < 12; i++) stim[i] = VAL_W'($urandom_range(0, 20));
        run(4, 3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) stim[i] = VAL_W'($urandom_range(500, 1000));
        run(4, 3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 16; i++) stim[i] = VAL_W'($urandom_range(0, 100));
        stim_n    = 16;
        stim_cols = 4;
        gap_en    = 1'b0;
        start     = 1'b1;
        num_rows  = DIM_W'(4);
        num_cols  = DIM_W'(4);
        tick();
        start = 1'b0;
        k = 0;
        while (!sad_ready && k < 20) begin
            tick();
            k++;
        end
        chk("stream_reached", 64'(sad_ready), 64'(1));
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("reset_midstream", 64'({busy, sad_ready, res_valid}), 64'(0));
        tick();
        Reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) stim[i] = VAL_W'($urandom_range(0, 100));
        run(2, 2, 1'b0, 1'b1, 1'b0);

        // Randomized windows, some with stalls and all-ones candidates.
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(1, 6);
            c = $urandom_range(1, 6);
            for (int i = 0; i < r * c; i++) begin
                stim[i] = ($urandom_range(0, 7) == 0) ? '1 : VAL_W'($urandom_range(0, 40));
            end
            run(r, c, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
